// File: rtl/brq_register_file_mp.sv
// Multi-port flip-flop register file with optional write-through bypass,
// dummy-instruction R0 and a busy scoreboard for long-latency writebacks.
module brq_register_file_mp #(
    parameter bit          RV32E             = 1'b0,
    parameter int unsigned DataWidth         = 32,
    parameter int unsigned NumRead           = 2,
    parameter int unsigned NumWrite          = 2,
    parameter bit          WriteThrough      = 1'b0,
    parameter bit          DummyInstructions = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          test_en_i,
    input  logic                          dummy_instr_id_i,
    input  logic [NumRead*5-1:0]          raddr_i,
    output logic [NumRead*DataWidth-1:0]  rdata_o,
    output logic [NumRead-1:0]            rbusy_o,
    input  logic [NumWrite*5-1:0]         waddr_i,
    input  logic [NumWrite*DataWidth-1:0] wdata_i,
    input  logic [NumWrite-1:0]           we_i,
    input  logic [NumWrite-1:0]           wclr_i,
    input  logic                          sb_set_i,
    input  logic [4:0]                    sb_addr_i,
    input  logic                          sb_flush_i,
    output logic [31:0]                   busy_vec_o
);

    // Addresses that map onto a real architectural register.
    localparam logic [31:0] LegalMask = RV32E ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    // Entry 0 is the dummy R0; it is only ever written when dummies are enabled.
    logic [DataWidth-1:0] rf_q [32];
    logic [DataWidth-1:0] rf_d [32];
    logic [31:0]          rf_we;
    logic [31:0]          wr_ok;
    logic [31:0]          busy_q;
    logic [31:0]          busy_d;
    logic [NumRead-1:0]   rb_mask;
    logic                 unused_test_en;

    assign unused_test_en = test_en_i;
    assign wr_ok          = {LegalMask[31:1], DummyInstructions && dummy_instr_id_i};
    assign busy_vec_o     = busy_q;

    // Resolve writes per register; a later port overrides an earlier one.
    always_comb begin
        rf_we = '0;
        for (int r = 0; r < 32; r++) begin
            rf_d[r] = '0;
        end
        for (int k = 0; k < NumWrite; k++) begin
            for (int r = 0; r < 32; r++) begin
                if (we_i[k] && waddr_i[5*k +: 5] == 5'(r) && wr_ok[r]) begin
                    rf_we[r] = 1'b1;
                    rf_d[r]  = wdata_i[DataWidth*k +: DataWidth];
                end
            end
        end
    end

    // Register storage, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < 32; r++) begin
                rf_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (rf_we[r]) begin
                    rf_q[r] <= rf_d[r];
                end
            end
        end
    end

    // Scoreboard next state: retire clears, issue sets, flush wins over all.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NumWrite; k++) begin
            if (we_i[k] && wclr_i[k]) begin
                busy_d[waddr_i[5*k +: 5]] = 1'b0;
            end
        end
        if (sb_set_i && sb_addr_i != 5'd0 && LegalMask[sb_addr_i]) begin
            busy_d[sb_addr_i] = 1'b1;
        end
        if (sb_flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard flops, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports with optional same-cycle bypass of data and busy retire.
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        rb_mask = '0;
        for (int p = 0; p < NumRead; p++) begin
            if (raddr_i[5*p +: 5] == 5'd0) begin
                if (DummyInstructions && dummy_instr_id_i) begin
                    rdata_o[DataWidth*p +: DataWidth] = rf_q[0];
                end
            end else if (LegalMask[raddr_i[5*p +: 5]]) begin
                rdata_o[DataWidth*p +: DataWidth] = rf_q[raddr_i[5*p +: 5]];
                if (WriteThrough) begin
                    for (int k = 0; k < NumWrite; k++) begin
                        if (we_i[k] && waddr_i[5*k +: 5] == raddr_i[5*p +: 5]) begin
                            rdata_o[DataWidth*p +: DataWidth] =
                                wdata_i[DataWidth*k +: DataWidth];
                            if (wclr_i[k]) begin
                                rb_mask[p] = 1'b1;
                            end
                        end
                    end
                    if (sb_set_i && sb_addr_i == raddr_i[5*p +: 5]) begin
                        rb_mask[p] = 1'b0;
                    end
                end
            end
            rbusy_o[p] = busy_q[raddr_i[5*p +: 5]] && !rb_mask[p];
        end
    end

endmodule

// File: tb/tb_brq_register_file_mp.sv
// Bench for brq_register_file_mp: two configurations driven in lockstep,
// directed steps then random traffic against a per-register array model.
module tb_brq_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dummy;
    logic [9:0]  raddr;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic [1:0]  wclr;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        sb_flush;

    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic [31:0] bv_a, bv_b;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [2][32];
    logic [31:0] bsy [2];
    int          words [2];
    bit          wt [2];
    bit          dm [2];

    always #5 clk = ~clk;

    brq_register_file_mp #(
        .RV32E(1'b0), .DataWidth(32), .NumRead(2), .NumWrite(2),
        .WriteThrough(1'b0), .DummyInstructions(1'b0)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
        .dummy_instr_id_i(dummy),
        .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wclr_i(wclr),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr), .sb_flush_i(sb_flush),
        .busy_vec_o(bv_a)
    );

    brq_register_file_mp #(
        .RV32E(1'b1), .DataWidth(32), .NumRead(2), .NumWrite(2),
        .WriteThrough(1'b1), .DummyInstructions(1'b1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
        .dummy_instr_id_i(dummy),
        .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wclr_i(wclr),
        .sb_set_i(sb_set), .sb_addr_i(sb_addr), .sb_flush_i(sb_flush),
        .busy_vec_o(bv_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(int i, logic [4:0] a);
        logic [31:0] v = 32'h0;
        if (a == 5'd0) begin
            if (dm[i] && dummy) v = mem[i][0];
        end else if (int'(a) < words[i]) begin
            v = mem[i][a];
            if (wt[i]) begin
                for (int k = 0; k < 2; k++)
                    if (we[k] && waddr[5*k +: 5] == a) v = wdata[32*k +: 32];
            end
        end
        return v;
    endfunction

    function automatic logic m_rbusy(int i, logic [4:0] a);
        logic b = bsy[i][a];
        bit   ret = 1'b0;
        if (wt[i]) begin
            for (int k = 0; k < 2; k++)
                if (we[k] && wclr[k] && waddr[5*k +: 5] == a) ret = 1'b1;
            if (ret && !(sb_set && sb_addr == a)) b = 1'b0;
        end
        return b;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            bsy[i] = '0;
            for (int r = 0; r < 32; r++) mem[i][r] = '0;
        end
    endtask

    task automatic m_update();
        logic [4:0] a;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 2; k++) begin
                a = waddr[5*k +: 5];
                if (we[k]) begin
                    if (a == 5'd0) begin
                        if (dm[i] && dummy) mem[i][0] = wdata[32*k +: 32];
                    end else if (int'(a) < words[i]) begin
                        mem[i][a] = wdata[32*k +: 32];
                    end
                end
            end
            if (sb_flush) begin
                bsy[i] = '0;
            end else begin
                for (int k = 0; k < 2; k++)
                    if (we[k] && wclr[k]) bsy[i][waddr[5*k +: 5]] = 1'b0;
                if (sb_set && sb_addr != 5'd0 && int'(sb_addr) < words[i])
                    bsy[i][sb_addr] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("a_rdata%0d", p), rdata_a[32*p +: 32],
                m_read(0, raddr[5*p +: 5]));
            chk($sformatf("b_rdata%0d", p), rdata_b[32*p +: 32],
                m_read(1, raddr[5*p +: 5]));
            chk($sformatf("a_rbusy%0d", p), 32'(rbusy_a[p]),
                32'(m_rbusy(0, raddr[5*p +: 5])));
            chk($sformatf("b_rbusy%0d", p), 32'(rbusy_b[p]),
                32'(m_rbusy(1, raddr[5*p +: 5])));
        end
        chk("a_busy_vec", bv_a, bsy[0]);
        chk("b_busy_vec", bv_b, bsy[1]);
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        dummy = 0; raddr = '0; waddr = '0; wdata = '0;
        we = '0; wclr = '0; sb_set = 0; sb_addr = '0; sb_flush = 0;
    endtask

    initial begin
        words[0] = 32; wt[0] = 1'b0; dm[0] = 1'b0;
        words[1] = 16; wt[1] = 1'b1; dm[1] = 1'b1;
        idle();
        rst_n = 1'b0;
        m_reset();
        #12;
        check_all();
        chk("rst_bv_b", bv_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write then read
        idle(); waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF; we = 2'b01;
        settle(); advance();
        idle(); raddr = {5'd0, 5'd5};
        settle();
        chk("x5_a", rdata_a[31:0], 32'hDEADBEEF);
        chk("x0_a", rdata_a[63:32], 32'h0);
        advance();

        // Same-register write on both ports: port 1 wins
        idle(); waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; we = 2'b11;
        settle(); advance();
        idle(); raddr[4:0] = 5'd7;
        settle();
        chk("prio_a", rdata_a[31:0], 32'h22);
        chk("prio_b", rdata_b[31:0], 32'h22);
        advance();

        // Same-cycle bypass only on the write-through instance
        idle(); waddr[9:5] = 5'd9; wdata[63:32] = 32'hA5A5A5A5; we = 2'b10;
        raddr[4:0] = 5'd9;
        settle();
        chk("wt_b", rdata_b[31:0], 32'hA5A5A5A5);
        chk("wt_a", rdata_a[31:0], 32'h0);
        advance();

        // Scoreboard set, set-beats-clear, then flush
        idle(); sb_set = 1; sb_addr = 5'd12;
        settle(); advance();
        idle();
        settle();
        chk("sb_set_a", bv_a, 32'h0000_1000);
        chk("sb_set_b", bv_b, 32'h0000_1000);
        advance();
        idle(); waddr[4:0] = 5'd12; wdata[31:0] = 32'h1234; we = 2'b01;
        wclr = 2'b01; sb_set = 1; sb_addr = 5'd12; raddr[4:0] = 5'd12;
        settle();
        chk("sb_nomask_b", 32'(rbusy_b[0]), 32'h1);
        advance();
        idle(); raddr[4:0] = 5'd12;
        settle();
        chk("sb_keep_a", bv_a, 32'h0000_1000);
        chk("sb_data_a", rdata_a[31:0], 32'h1234);
        advance();
        idle(); waddr[4:0] = 5'd12; we = 2'b01; wclr = 2'b01; raddr[4:0] = 5'd12;
        settle();
        chk("retire_mask_b", 32'(rbusy_b[0]), 32'h0);
        chk("retire_nomask_a", 32'(rbusy_a[0]), 32'h1);
        advance();
        idle(); sb_set = 1; sb_addr = 5'd3;
        settle(); advance();
        idle(); sb_flush = 1; sb_set = 1; sb_addr = 5'd5;
        settle(); advance();
        idle();
        settle();
        chk("flush_a", bv_a, 32'h0);
        chk("flush_b", bv_b, 32'h0);
        advance();

        // Illegal address on the RV32E instance
        idle(); waddr[4:0] = 5'd20; wdata[31:0] = 32'h5; we = 2'b01;
        sb_set = 1; sb_addr = 5'd20;
        settle(); advance();
        idle(); raddr[4:0] = 5'd20;
        settle();
        chk("e_rd_b", rdata_b[31:0], 32'h0);
        chk("e_bv_b", bv_b, 32'h0);
        chk("e_rd_a", rdata_a[31:0], 32'h5);
        chk("e_bv_a", bv_a, 32'h0010_0000);
        advance();

        // Dummy R0
        idle(); dummy = 1; waddr[4:0] = 5'd0; wdata[31:0] = 32'h77; we = 2'b01;
        settle(); advance();
        idle(); dummy = 1;
        settle();
        chk("dm1_b", rdata_b[31:0], 32'h77);
        chk("dm1_a", rdata_a[31:0], 32'h0);
        dummy = 0;
        settle();
        chk("dm0_b", rdata_b[31:0], 32'h0);
        advance();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            dummy = 1'($urandom);
            waddr[4:0] = 5'($urandom_range(0, 23));
            waddr[9:5] = ($urandom_range(0, 1) == 0) ? waddr[4:0]
                                                     : 5'($urandom_range(0, 31));
            wdata = {$urandom, $urandom};
            we = 2'($urandom);
            wclr = 2'($urandom);
            raddr[4:0] = ($urandom_range(0, 1) == 0) ? waddr[9:5]
                                                     : 5'($urandom_range(0, 23));
            raddr[9:5] = 5'($urandom_range(0, 31));
            sb_set = ($urandom_range(0, 2) == 0);
            sb_addr = ($urandom_range(0, 3) == 0) ? raddr[4:0]
                                                  : 5'($urandom_range(0, 23));
            sb_flush = ($urandom_range(0, 40) == 0);
            settle(); advance();
        end

        // Reset asserted between clock edges clears everything at once
        idle(); waddr[4:0] = 5'd5; wdata[31:0] = 32'hCAFE; we = 2'b01;
        sb_set = 1; sb_addr = 5'd6;
        settle(); advance();
        idle(); raddr = {5'd6, 5'd5};
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all();
        chk("mrst_rd_a", rdata_a[31:0], 32'h0);
        chk("mrst_bv_a", bv_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        settle();
        chk("post_rst_b", rdata_b[31:0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brq_register_file_mp.md
Name: brq_register_file_mp

Overview:
- Parametrised successor to the core's flip-flop register file.
- Generalised to N read ports and M write ports for dual-issue/LSU writeback.
- Adds optional write-through bypass and a per-register busy scoreboard for long-latency writebacks (mul/div/load); keeps dummy-instruction R0 support.
- Sits between the ID stage (reads, scoreboard issue) and the WB stage (writes, scoreboard clear).

Parameters:
- RV32E, 0, 1 selects 16 architectural registers; addresses 16..31 are treated as illegal.
- DataWidth, 32, register width in bits.
- NumRead, 2, number of read ports (1..4).
- NumWrite, 2, number of write ports (1..3); a higher port index has higher priority.
- WriteThrough, 0, 1 makes a same-cycle write visible on the read data.
- DummyInstructions, 0, 1 makes R0 a real register for dummy instructions.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- test_en_i  in  1  unused in this block
- dummy_instr_id_i  in  1  current ID instruction is a dummy
- raddr_i  in  NumRead*5  read addresses; port p uses bits [5p+4:5p]
- rdata_o  out  NumRead*DataWidth  read data
- rbusy_o  out  NumRead  addressed register has a pending writeback
- waddr_i  in  NumWrite*5  write addresses
- wdata_i  in  NumWrite*DataWidth  write data
- we_i  in  NumWrite  write enables
- wclr_i  in  NumWrite  this write retires the scoreboard entry of its waddr
- sb_set_i  in  1  mark sb_addr_i busy (long-latency op issued)
- sb_addr_i  in  5  destination register to mark busy
- sb_flush_i  in  1  clear all busy bits (pipeline flush)
- busy_vec_o  out  32  registered busy bits; bits above NUM_WORDS-1 are 0

Behaviour:
- Reset (asynchronous, rst_ni=0): all registers, dummy R0 and busy bits clear to 0. rdata_o therefore reads 0 and rbusy_o/busy_vec_o read 0.
- Reads are combinational from registered state. rdata_o[p] = reg[raddr[p]].
  - R0 reads 0, except dummy R0 content when DummyInstructions=1 and dummy_instr_id_i=1.
  - Illegal addresses (RV32E, addr>=16) read 0.
- Writes take effect on the clock edge; write latency is 1 cycle.
  - Writes to R0 are dropped, except the dummy R0 write (we_i[k] & dummy_instr_id_i, DummyInstructions=1).
  - Writes to illegal addresses are dropped.
  - Several ports writing the same register in one cycle: the highest-index enabled port wins, and its data is stored.
- WriteThrough=1: a read of address A while any enabled write port targets A (A≠0, legal) returns that write's data (highest-index port) in the same cycle. WriteThrough=0 returns the old value.
- Scoreboard: busy[31:1] are flip-flops; busy[0] is constant 0.
  - A write with we_i[k]&wclr_i[k] clears busy[waddr[k]] at the next edge.
  - sb_set_i sets busy[sb_addr_i] at the next edge; it is ignored for R0 and illegal addresses.
  - Set and clear of the same register in the same cycle: set wins, because it is a new issue.
  - sb_flush_i clears every bit and overrides a simultaneous sb_set_i.
  - Setting an already-busy register leaves it busy; clearing a non-busy register is a no-op.
- rbusy_o[p] = busy[raddr[p]].
  - With WriteThrough=1, a same-cycle retiring write (we&wclr) to that address masks rbusy_o[p] to 0 unless sb_set_i targets the same address.
  - With WriteThrough=0, rbusy_o[p] is unmasked.
- Register writes are unaffected by busy state; the block does not stall, the consumer does.
- A reset asserted mid-operation clears all state immediately; no pending writes survive.

Test Plan:
- Reset, then write 0xDEADBEEF to x5 on port 0; next cycle raddr0=5 -> rdata0=0xDEADBEEF; raddr1=0 -> 0.
- Port0 writes x7=0x11, port1 writes x7=0x22 in the same cycle -> x7 reads 0x22 afterwards.
- WriteThrough=1: port1 writes x9=0xA5A5A5A5 while raddr0=9 -> rdata0=0xA5A5A5A5 in the same cycle. With WriteThrough=0 it reads the old 0.
- sb_set_i to x12 -> busy_vec_o[12]=1 next cycle. Then a write with wclr to x12 and sb_set_i to x12 in the same cycle -> busy stays 1, data updated. Then sb_flush_i -> busy_vec_o=0.
- RV32E=1: write x20=0x5, sb_set_i to x20 -> the write is dropped, raddr=20 reads 0, busy_vec_o[20]=0.
- DummyInstructions=1: dummy write R0=0x77 -> reads 0x77 when dummy_instr_id_i=1 and 0 when it is 0. Assert rst_ni low mid-sequence -> all reads 0 and busy 0 immediately.
